uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ byte-stream requesters (e.g. CPU console, debug, logger).

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among N_REQ byte-stream
// requesters. A grant stays locked until a req_last beat, MAX_BURST beats, or a flush.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_en,
  input  logic                      tx_flush,
  input  logic                      tx_fifo_full,
  output logic                      tx_wr_en,
  output logic [DATA_W-1:0]         tx_wr_data,
  output logic                      grant_valid,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_ptr_q, last_ptr_d;
  logic             grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ID_W-1:0]   winner;
  logic              winner_found;
  int unsigned       idx;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              path_ready;
  logic              beat;
  logic [CNT_W-1:0]  count_inc;

  // Search starts just after the previous winner, so the last owner ranks lowest.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_ptr_q) + i) % N_REQ;
      if (!winner_found && req_valid[idx]) begin
        winner       = ID_W'(idx);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_comb begin
    path_ready = (state_q == ARB_XFER) && tx_en && !tx_fifo_full && !tx_flush;
    beat       = path_ready && sel_valid;
    count_inc  = count_q + CNT_W'(1);

    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = path_ready && (grant_id_q == ID_W'(i));
    end
    tx_wr_en   = beat;
    tx_wr_data = beat ? sel_data : '0;

    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_ptr_d    = last_ptr_q;
    grant_valid_d = grant_valid_q;
    count_d       = count_q;

    case (state_q)
      ARB_IDLE: begin
        if (tx_en && !tx_flush && winner_found) begin
          state_d       = ARB_XFER;
          grant_id_d    = winner;
          last_ptr_d    = winner;
          grant_valid_d = 1'b1;
          count_d       = '0;
        end
      end
      ARB_XFER: begin
        if (beat) begin
          count_d = count_inc;
          if (sel_last || (count_inc == CNT_W'(MAX_BURST))) begin
            state_d       = ARB_IDLE;
            grant_valid_d = 1'b0;
            count_d       = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Flush overrides everything but keeps last_ptr, demoting the flushed owner.
    if (tx_flush) begin
      state_d       = ARB_IDLE;
      grant_valid_d = 1'b0;
      count_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_id_q    <= '0;
      last_ptr_q    <= ID_W'(N_REQ - 1);
      grant_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_ptr_q    <= last_ptr_d;
      grant_valid_q <= grant_valid_d;
      count_q       <= count_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester BFMs feed per-requester beat queues,
// a monitor checks every TX write and every grant against expected queues.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 9;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_en;
  logic           tx_flush;
  logic           tx_fifo_full;
  logic           tx_wr_en;
  logic [W-1:0]   tx_wr_data;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_en(tx_en), .tx_flush(tx_flush), .tx_fifo_full(tx_fifo_full),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int beats;
  } gexp_t;

  gexp_t        grant_exp[$];
  logic [W-1:0] exp_q[N][$];
  logic [W-1:0] src_data[N][$];
  logic         src_last[N][$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int id, input logic [W-1:0] d, input logic l);
    src_data[id].push_back(d);
    src_last[id].push_back(l);
    exp_q[id].push_back(d);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (tx_wr_en === 1'b1) seen++;
    end
    chk("wait_writes", seen, n);
  endtask

  task automatic wait_quiet(input int budget);
    int cyc  = 0;
    bit done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      done = (busy === 1'b0) && (req_valid == '0) && (src_data[0].size() == 0) &&
             (src_data[1].size() == 0) && (src_data[2].size() == 0) && (src_data[3].size() == 0);
    end
    chk("quiet_timeout", done, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, tx_wr_en, 0);
    chk({tag, "_wr_data"}, tx_wr_data, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_gvalid"}, grant_valid, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Requester BFM: a beat leaves its queue after a handshake seen at the falling edge.
  initial begin
    logic [N-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] === 1'b1 && src_data[i].size() > 0) begin
          void'(src_data[i].pop_front());
          void'(src_last[i].pop_front());
        end
        if (src_data[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*W +: W] = src_data[i][0];
          req_last[i]        = src_last[i][0];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*W +: W] = '0;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: grants, beats per grant, written data, and output invariants.
  initial begin
    logic         prev_gv;
    int           beats;
    int           exp_beats;
    gexp_t        g;
    logic [W-1:0] e;
    prev_gv   = 1'b0;
    beats     = 0;
    exp_beats = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (grant_valid === 1'b1 && !prev_gv) begin
          if (grant_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got id %0d expected no grant", grant_id);
            exp_beats = 0;
          end else begin
            g = grant_exp.pop_front();
            chk("grant_order", grant_id, g.id);
            exp_beats = g.beats;
          end
          beats = 0;
        end
        chk("wr_while_full", tx_wr_en & tx_fifo_full, 0);
        if (tx_wr_en === 1'b1) begin
          beats++;
          chk("ready_onehot", req_ready, 32'(1) << grant_id);
          if (exp_q[grant_id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_extra: got 0x%0h from req %0d expected no beat", tx_wr_data, grant_id);
          end else begin
            e = exp_q[grant_id].pop_front();
            chk("wr_data", tx_wr_data, e);
          end
        end else begin
          chk("wr_data_idle", tx_wr_data, 0);
        end
        if (grant_valid === 1'b0 && prev_gv) chk("beats_per_grant", beats, exp_beats);
        prev_gv = (grant_valid === 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    rst          = 1'b1;
    tx_en        = 1'b0;
    tx_flush     = 1'b0;
    tx_fifo_full = 1'b0;
    repeat (3) step;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    // Single requester, held off by tx_en=0 first.
    grant_exp.push_back('{0, 3});
    push_beat(0, 9'h041, 1'b0);
    push_beat(0, 9'h042, 1'b0);
    push_beat(0, 9'h043, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("en0_no_grant", grant_valid, 0);
      chk("en0_busy", busy, 0);
    end
    step;
    tx_en = 1'b1;
    @(negedge clk);
    chk("t1_arb_wr", tx_wr_en, 0);
    chk("t1_arb_gv", grant_valid, 0);
    @(negedge clk);
    chk("t1_b0_wr", tx_wr_en, 1);
    chk("t1_b0_data", tx_wr_data, 9'h041);
    chk("t1_b0_gv", grant_valid, 1);
    chk("t1_b0_busy", busy, 1);
    @(negedge clk);
    chk("t1_b1_data", tx_wr_data, 9'h042);
    @(negedge clk);
    chk("t1_b2_data", tx_wr_data, 9'h043);
    @(negedge clk);
    chk("t1_rel_gv", grant_valid, 0);
    chk("t1_rel_wr", tx_wr_en, 0);
    chk("t1_rel_busy", busy, 0);

    // Fairness after reset: order 0,1,2,3,0,1,2,3 with a write every 2 cycles.
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        grant_exp.push_back('{i, 1});
        push_beat(i, 9'(((p == 0) ? 9'h0A0 : 9'h0B0) + i), 1'b1);
      end
    end
    wait_writes(1, 10);
    n   = 0;
    cyc = 0;
    while (n < 7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (tx_wr_en === 1'b1) n++;
    end
    chk("fair_span_cycles", cyc, 14);
    wait_quiet(20);

    // Burst cap: 40-beat packet on req1 interleaved with req2.
    grant_exp.push_back('{1, 16});
    grant_exp.push_back('{2, 3});
    grant_exp.push_back('{1, 16});
    grant_exp.push_back('{1, 8});
    for (int k = 0; k < 40; k++) push_beat(1, 9'(9'h100 + k), k == 39);
    push_beat(2, 9'h1AA, 1'b0);
    push_beat(2, 9'h0BB, 1'b0);
    push_beat(2, 9'h1CC, 1'b1);
    wait_quiet(200);

    // Backpressure mid-packet, then again with only the last beat pending.
    grant_exp.push_back('{3, 6});
    for (int k = 0; k < 6; k++) push_beat(3, 9'(9'h030 + k), k == 5);
    wait_writes(2, 20);
    step;
    tx_fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("full_wr", tx_wr_en, 0);
      chk("full_ready", req_ready, 0);
      chk("full_gv", grant_valid, 1);
    end
    step;
    tx_fifo_full = 1'b0;
    wait_writes(3, 20);
    step;
    tx_fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_last_wr", tx_wr_en, 0);
      chk("full_last_gv", grant_valid, 1);
    end
    step;
    tx_fifo_full = 1'b0;
    wait_quiet(20);

    // Flush mid-packet of req0 with req1 waiting: req1 goes next.
    grant_exp.push_back('{0, 2});
    grant_exp.push_back('{1, 2});
    grant_exp.push_back('{0, 4});
    for (int k = 0; k < 6; k++) push_beat(0, 9'(9'h050 + k), k == 5);
    push_beat(1, 9'h060, 1'b0);
    push_beat(1, 9'h061, 1'b1);
    wait_writes(2, 20);
    step;
    tx_flush = 1'b1;
    @(negedge clk);
    chk("flush_wr", tx_wr_en, 0);
    chk("flush_ready", req_ready, 0);
    @(negedge clk);
    chk("flush_gv", grant_valid, 0);
    chk("flush_busy", busy, 0);
    step;
    tx_flush = 1'b0;
    wait_quiet(50);

    // tx_en stall keeps the grant; reset mid-packet with tx_en low blocks new grants.
    grant_exp.push_back('{2, 3});
    grant_exp.push_back('{2, 2});
    for (int k = 0; k < 5; k++) push_beat(2, 9'(9'h070 + k), k == 4);
    wait_writes(2, 20);
    step;
    tx_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("en0_stall_wr", tx_wr_en, 0);
      chk("en0_stall_gv", grant_valid, 1);
      chk("en0_stall_busy", busy, 1);
    end
    step;
    tx_en = 1'b1;
    wait_writes(1, 10);
    step;
    rst   = 1'b1;
    tx_en = 1'b0;
    @(negedge clk);
    chk("rst_cycle_wr", tx_wr_en, 0);
    step;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_grant", grant_valid, 0);
    end
    step;
    tx_en = 1'b1;
    wait_quiet(50);

    repeat (2) @(negedge clk);
    chk("exp_data_left", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
    chk("grant_exp_left", grant_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
